// File: rtl/calc_core_mp.sv
// calc_core_mp: N request ports share one add/sub/shift ALU through a round-robin arbiter.
// Latency: cmd+op1 at T, op2 at T+1, grant no earlier than T+2, one-cycle response at T+3 (T+2+NUM_PORTS worst case).
// Backpressure: none. A port ignores cmd_in until its single outstanding op has been answered.
// Optional feature macro: CALC_SHIFT_EN. When it is defined, cmds 5/6 are shl/shr. When it is not,
// cmds 5/6 get the invalid response and no shifter is built.
module calc_core_mp #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32
) (
    input  logic                          c_clk,
    input  logic                          reset_n,
    input  logic [NUM_PORTS*4-1:0]        cmd_in,
    input  logic [NUM_PORTS*DATA_W-1:0]   data_in,
    output logic [NUM_PORTS*2-1:0]        out_resp,
    output logic [NUM_PORTS*DATA_W-1:0]   out_data
);

    // Width of a port index. It is kept at least 1 bit so a single-port build still elaborates.
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // Command encodings
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
`ifdef CALC_SHIFT_EN
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;
    // The shift amount uses only the low bits of op2. The upper op2 bits are ignored.
    localparam int         SH_W    = $clog2(DATA_W);
`endif

    // Response codes
    localparam logic [1:0] RESP_OK  = 2'd1;
    localparam logic [1:0] RESP_OVF = 2'd2;
    localparam logic [1:0] RESP_INV = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP2  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Per-port context. Each port holds at most one outstanding operation.
    state_t              r_state [NUM_PORTS];
    logic [3:0]          r_cmd   [NUM_PORTS];
    logic [DATA_W-1:0]   r_op1   [NUM_PORTS];
    logic [DATA_W-1:0]   r_op2   [NUM_PORTS];

    // Round-robin pointer: the most recently granted port
    logic [PW-1:0]       r_ptr;

    // Registered response outputs. They are all zero except in the single response cycle.
    logic [NUM_PORTS*2-1:0]      r_out_resp;
    logic [NUM_PORTS*DATA_W-1:0] r_out_data;

    // Arbiter and ALU nets
    logic [NUM_PORTS-1:0] w_wait;
    logic                 w_gnt_vld;
    logic [PW-1:0]        w_gnt_idx;
    logic [3:0]           w_alu_cmd;
    logic [DATA_W-1:0]    w_alu_op1;
    logic [DATA_W-1:0]    w_alu_op2;
    logic [DATA_W:0]      w_sum;
    logic [DATA_W-1:0]    w_diff;
    logic [1:0]           w_res_resp;
    logic [DATA_W-1:0]    w_res_data;

    // Collect the ports that are waiting for the ALU
    always_comb begin
        w_wait = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_wait[p] = (r_state[p] == ST_WAIT);
        end
    end

    // Round-robin pick. The first pass scans ports above r_ptr in ascending order.
    // The second pass wraps around to ports at or below r_ptr, which gives ptr+1..ptr search order.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!w_gnt_vld && w_wait[p] && (PW'(p) > r_ptr)) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = PW'(p);
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!w_gnt_vld && w_wait[p] && (PW'(p) <= r_ptr)) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = PW'(p);
            end
        end
    end

    // Route the granted port's operands into the shared ALU
    always_comb begin
        w_alu_cmd = r_cmd[w_gnt_idx];
        w_alu_op1 = r_op1[w_gnt_idx];
        w_alu_op2 = r_op2[w_gnt_idx];
    end

    // Shared unsigned ALU. Overflow, underflow and invalid commands all return data 0.
    always_comb begin
        w_sum      = {1'b0, w_alu_op1} + {1'b0, w_alu_op2};
        w_diff     = w_alu_op1 - w_alu_op2;
        w_res_resp = RESP_INV;
        w_res_data = '0;
        case (w_alu_cmd)
            CMD_ADD: begin
                if (w_sum[DATA_W]) begin
                    w_res_resp = RESP_OVF;
                end else begin
                    w_res_resp = RESP_OK;
                    w_res_data = w_sum[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (w_alu_op2 > w_alu_op1) begin
                    w_res_resp = RESP_OVF;
                end else begin
                    w_res_resp = RESP_OK;
                    w_res_data = w_diff;
                end
            end
`ifdef CALC_SHIFT_EN
            CMD_SHL: begin
                w_res_resp = RESP_OK;
                w_res_data = w_alu_op1 << w_alu_op2[SH_W-1:0];
            end
            CMD_SHR: begin
                w_res_resp = RESP_OK;
                w_res_data = w_alu_op1 >> w_alu_op2[SH_W-1:0];
            end
`endif
            default: begin
                w_res_resp = RESP_INV;
                w_res_data = '0;
            end
        endcase
    end

    // Per-port FSMs, arbiter pointer and registered response, all in one sequential block
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_state[p] <= ST_IDLE;
                r_cmd[p]   <= '0;
                r_op1[p]   <= '0;
                r_op2[p]   <= '0;
            end
            r_ptr      <= PW'(NUM_PORTS - 1);
            r_out_resp <= '0;
            r_out_data <= '0;
        end else begin
            // Responses last a single cycle, so they are cleared by default each cycle
            r_out_resp <= '0;
            r_out_data <= '0;
            if (w_gnt_vld) begin
                r_ptr <= w_gnt_idx;
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                case (r_state[p])
                    ST_IDLE: begin
                        if (cmd_in[4*p +: 4] != 4'd0) begin
                            r_cmd[p]   <= cmd_in[4*p +: 4];
                            r_op1[p]   <= data_in[DATA_W*p +: DATA_W];
                            r_state[p] <= ST_OP2;
                        end
                    end
                    ST_OP2: begin
                        // cmd_in is deliberately ignored while the second operand is captured
                        r_op2[p]   <= data_in[DATA_W*p +: DATA_W];
                        r_state[p] <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        // Returning to IDLE on grant means the port can accept a new
                        // command in the same cycle that its response is presented
                        if (w_gnt_vld && (w_gnt_idx == PW'(p))) begin
                            r_out_resp[2*p +: 2]           <= w_res_resp;
                            r_out_data[DATA_W*p +: DATA_W] <= w_res_data;
                            r_state[p]                     <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state[p] <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign out_resp = r_out_resp;
    assign out_data = r_out_data;

endmodule
